// File: rtl/reg_scoreboard.sv
// reg_scoreboard: read-after-write hazard tracker for a 16-entry register file.
//
// Each register has a small in-flight counter. An issued instruction with a
// destination bumps that counter; a writeback (the register-file write port)
// drops it. Issue is refused while any register the instruction reads still
// has a write in flight, or when the destination counter is full.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   issue_valid       decode presents an instruction
//   issue_src1/src2   source registers (src2 only when issue_use_src2)
//   issue_dest        destination register (only when issue_wb_en)
//   issue_ready       combinational accept, independent of issue_valid
//   wb_wb_en/dest_wb  writeback port, shared with the register file
//   flush             squash everything in flight
//   busy_vec          registered: bit i set when register i has a write pending
//   inflight_total    registered running sum of all counters
//   stall_count       saturating count of cycles decode was held off
//   err_underflow     sticky: writeback seen for a register with nothing pending
module reg_scoreboard #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned STALL_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_src1,
  input  logic [ADDR_W-1:0]   issue_src2,
  input  logic                issue_use_src2,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic                issue_wb_en,
  output logic                issue_ready,
  input  logic                wb_wb_en,
  input  logic [ADDR_W-1:0]   dest_wb,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [7:0]          inflight_total,
  output logic [STALL_W-1:0]  stall_count,
  output logic                err_underflow
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0]    r_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [7:0]          r_total;
  logic [STALL_W-1:0]  r_stall;
  logic                r_err;

  logic [CNT_W-1:0]    w_eff   [NUM_REGS];
  logic [CNT_W-1:0]    w_cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] w_wb_hit;
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_busy_d;
  logic                w_ready;
  logic                w_fire;
  logic                w_underflow;
  logic                w_stall_ev;
  logic [7:0]          w_total_d;

  // The register file writes on the falling edge, so a same-cycle writeback is
  // already visible to the issuing instruction: hazards use the post-writeback
  // count.
  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      w_wb_hit[r] = wb_wb_en && (dest_wb == ADDR_W'(r)) && (r_cnt[r] != '0);
      w_eff[r]    = r_cnt[r] - CNT_W'(w_wb_hit[r]);
    end
  end

  always_comb begin
    w_ready = !flush
           && (w_eff[issue_src1] == '0)
           && (!issue_use_src2 || (w_eff[issue_src2] == '0))
           && (!issue_wb_en || (w_eff[issue_dest] != CntMax));
  end

  assign w_fire      = issue_valid && w_ready;
  assign w_underflow = wb_wb_en && !flush && (r_cnt[dest_wb] == '0);
  assign w_stall_ev  = issue_valid && !w_ready && !flush;

  always_comb begin
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      w_inc[r] = w_fire && issue_wb_en && (issue_dest == ADDR_W'(r));
      if (flush) begin
        w_cnt_d[r] = '0;
      end else begin
        w_cnt_d[r] = r_cnt[r] + CNT_W'(w_inc[r]) - CNT_W'(w_wb_hit[r]);
      end
      w_busy_d[r] = (w_cnt_d[r] != '0);
    end
  end

  // At most one increment and one decrement per cycle, so the running sum only
  // needs a +1/-1 adjustment rather than re-adding every counter.
  always_comb begin
    if (flush) begin
      w_total_d = '0;
    end else begin
      w_total_d = r_total + 8'(|w_inc) - 8'(|w_wb_hit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= '0;
      end
      r_busy  <= '0;
      r_total <= '0;
      r_stall <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        r_cnt[r] <= w_cnt_d[r];
      end
      r_busy  <= w_busy_d;
      r_total <= w_total_d;
      if (w_stall_ev && (r_stall != '1)) begin
        r_stall <= r_stall + 1'b1;
      end
      if (w_underflow) begin
        r_err <= 1'b1;
      end
    end
  end

  assign issue_ready    = w_ready;
  assign busy_vec       = r_busy;
  assign inflight_total = r_total;
  assign stall_count    = r_stall;
  assign err_underflow  = r_err;

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks outstanding writes to the 16-entry register file and gates instruction issue on read-after-write hazards.
- Sits between decode/issue and the register file.
- Issue marks the destination pending; writeback (same signals that drive the register file write port) clears it.
- Provides a stall handshake toward decode, a busy vector for debug/forwarding, and a saturating stall counter.

Parameters:
NUM_REGS, 16, number of architectural registers tracked
ADDR_W, 4, register index width (log2 NUM_REGS)
CNT_W, 2, per-register in-flight counter width; max in-flight writes per register = 2^CNT_W-1 (3)
STALL_W, 16, stall cycle counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
issue_valid  input  1  decode presents an instruction
issue_src1  input  ADDR_W  first source register
issue_src2  input  ADDR_W  second source register
issue_use_src2  input  1  instruction reads src2
issue_dest  input  ADDR_W  destination register
issue_wb_en  input  1  instruction writes issue_dest
issue_ready  output  1  scoreboard accepts instruction this cycle
wb_wb_en  input  1  writeback write enable (same as register file)
dest_wb  input  ADDR_W  writeback destination (same as register file)
flush  input  1  squash all in-flight instructions
busy_vec  output  NUM_REGS  bit i = register i has count > 0
inflight_total  output  8  sum of all per-register counts
stall_count  output  STALL_W  saturating count of stalled cycles
err_underflow  output  1  sticky: writeback to register with count 0

Behaviour:
- Reset (rst=1 at posedge): all counts 0, busy_vec=0, inflight_total=0, stall_count=0, err_underflow=0. Reset dominates flush, issue and wb in the same cycle.
- Writeback hit:
  - wb_hit(r) = wb_wb_en && dest_wb==r && cnt[r]!=0.
  - eff_cnt[r] = cnt[r] - wb_hit(r).
  - The register file writes on the falling edge, so a same-cycle read sees the new value. Same-cycle writeback therefore unblocks issue.
- issue_ready is combinational:
  - Ready = !flush && eff_cnt[src1]==0 && (!issue_use_src2 || eff_cnt[src2]==0) && (!issue_wb_en || eff_cnt[dest] != 2^CNT_W-1).
  - Asserted independent of issue_valid.
- Fire:
  - fire = issue_valid && issue_ready.
  - On fire with issue_wb_en, cnt[dest] increments at the next edge.
- Per-register next count: cnt[r] + (fire && issue_wb_en && issue_dest==r) - wb_hit(r). Simultaneous issue and writeback to the same register leaves the count unchanged.
- Underflow: wb_wb_en to a register with cnt 0 leaves counts unchanged and sets err_underflow (sticky until rst).
- Flush:
  - All counts cleared to 0 at the next edge; issue_ready=0 during the flush cycle.
  - A writeback in the flush cycle is ignored by the counters and does not raise err_underflow.
- Outputs:
  - busy_vec and inflight_total are registered views of the counts, valid the cycle after the edge that updates them.
  - inflight_total is maintained as a registered running sum, not a 16-way adder.
- stall_count: increments each cycle with issue_valid && !issue_ready && !flush; saturates at 2^STALL_W-1. Cleared only by rst.
- Latency: 0-cycle issue decision; 1 cycle from fire/wb to the visible busy_vec change.
- No internal FSM beyond the counters. Width rules: counts unsigned; increment saturation is prevented by the ready condition.

Test Plan:
- Reset, then issue dest=3 (wb_en=1) -> next cycle busy_vec=0x0008, inflight_total=1. Issue src1=3 -> issue_ready=0 and stall_count increments each cycle. Writeback with dest_wb=3 -> issue_ready=1 in that same cycle; busy_vec=0 on the next cycle.
- Three back-to-back issues to dest=5 -> cnt[5]=3. A fourth issue to dest=5 -> issue_ready=0. One writeback to 5 in the same cycle -> that fourth issue fires and cnt[5] stays 3.
- Issue dest=7 and writeback dest_wb=7 in the same cycle with cnt[7]=1 -> cnt[7] remains 1 and busy_vec[7]=1.
- Writeback dest_wb=9 with cnt[9]=0 -> err_underflow=1 and stays 1. Counts are unchanged.
- Fill registers 1, 2 and 4. Assert flush with issue_valid=1 -> issue_ready=0 and no fire. Next cycle busy_vec=0, inflight_total=0, and stall_count is unchanged for the flush cycle.
- Hold issue_valid with src1 busy for 70000 cycles (STALL_W=16) -> stall_count saturates at 0xFFFF. rst mid-stall -> all outputs 0 on the next cycle.
